pe_mac_cfg: RTL and testbench

Parametrised processing element for the systolic array. It supports two modes:
- **Output-stationary (OS):** accumulate `srca * srcb` locally.
- **Weight-stationary (WS):** hold a preloaded weight and add `srca * weight` to a partial sum entering from the neighbour.

Operands and control propagate to adjacent PEs with one register stage. The block adds valid qualification, a wide accumulator, round-to-nearest and optional saturation on the quantised result. It is the drop-in successor of the fixed 16-bit OS-only element in the array tile.

---
 rtl/pe_mac_cfg_if.sv | 33 +++
 rtl/pe_mac_cfg.sv | 130 +++++++++++++
 tb/tb_pe_mac_cfg.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_cfg_if.sv
// Operand, control and result bundle of one systolic-array processing element.
// The master drives the beat; the slave (the PE) returns pass-through and result.
interface pe_mac_cfg_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40
) ();
    logic                  mode_i;
    logic                  valid_i;
    logic                  clear_i;
    logic                  wload_i;
    logic [DATA_WIDTH-1:0] srca_i;
    logic [DATA_WIDTH-1:0] srcb_i;
    logic [ACC_WIDTH-1:0]  psum_i;

    logic                  valid_o;
    logic                  clear_o;
    logic                  wload_o;
    logic [DATA_WIDTH-1:0] srca_o;
    logic [DATA_WIDTH-1:0] srcb_o;
    logic [ACC_WIDTH-1:0]  psum_o;
    logic                  psum_vld_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output mode_i, valid_i, clear_i, wload_i, srca_i, srcb_i, psum_i,
        input  valid_o, clear_o, wload_o, srca_o, srcb_o, psum_o, psum_vld_o, result_o
    );

    modport slave (
        input  mode_i, valid_i, clear_i, wload_i, srca_i, srcb_i, psum_i,
        output valid_o, clear_o, wload_o, srca_o, srcb_o, psum_o, psum_vld_o, result_o
    );
endinterface

// File: rtl/pe_mac_cfg.sv
// Systolic processing element: output-stationary or weight-stationary MAC with a
// wide accumulator, round-half-up quantisation and optional output saturation.
module pe_mac_cfg #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned SAT        = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    pe_mac_cfg_if.slave bus
);
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned QW = ACC_WIDTH + 1;

    localparam logic signed [QW-1:0] RND_Q = QW'(1) << (FRAC_BITS - 1);
    localparam logic signed [QW-1:0] MAX_Q = {{(QW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] MIN_Q = {{(QW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // stage 0 registers
    logic [DATA_WIDTH-1:0]        r_srca;
    logic [DATA_WIDTH-1:0]        r_srcb;
    logic                         r_valid;
    logic                         r_clear;
    logic                         r_wload;
    logic                         r_mode;
    logic signed [DATA_WIDTH-1:0] r_weight;
    logic signed [ACC_WIDTH-1:0]  r_prod;
    logic signed [ACC_WIDTH-1:0]  r_psum_in;

    // stage 1 registers
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_psum_vld;

    logic signed [PW-1:0]         w_a_ext;
    logic signed [PW-1:0]         w_b_ext;
    logic signed [PW-1:0]         w_prod;
    logic                         w_mode_chg;
    logic signed [ACC_WIDTH-1:0]  w_acc_base;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic signed [QW-1:0]         w_round;
    logic signed [QW-1:0]         w_shift;
    logic [DATA_WIDTH-1:0]        w_result;

    // Multiplier: in WS the stored weight replaces srcb; a same-cycle load lands after this beat
    always_comb begin
        w_a_ext = PW'($signed(bus.srca_i));
        w_b_ext = r_mode ? PW'(r_weight) : PW'($signed(bus.srcb_i));
        w_prod  = w_a_ext * w_b_ext;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_srca    <= '0;
            r_srcb    <= '0;
            r_valid   <= 1'b0;
            r_clear   <= 1'b0;
            r_wload   <= 1'b0;
            r_mode    <= 1'b0;
            r_weight  <= '0;
            r_prod    <= '0;
            r_psum_in <= '0;
        end else begin
            r_srca    <= bus.srca_i;
            r_srcb    <= bus.srcb_i;
            r_valid   <= bus.valid_i;
            r_clear   <= bus.clear_i & bus.valid_i;
            r_wload   <= bus.wload_i;
            r_mode    <= bus.mode_i;
            r_prod    <= ACC_WIDTH'(w_prod);
            r_psum_in <= bus.psum_i;
            if (bus.wload_i) begin
                r_weight <= bus.srcb_i;
            end
        end
    end

    // OS folds into the local sum (restarting on clear); WS adds to the neighbour's psum
    always_comb begin
        w_mode_chg = (r_mode != bus.mode_i);
        w_acc_base = r_clear ? '0 : r_acc;
        w_acc_nxt  = r_mode ? (r_psum_in + r_prod) : (w_acc_base + r_prod);
    end

    // A mode switch flushes the accumulator and drops whatever beat is in stage 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc      <= '0;
            r_psum_vld <= 1'b0;
        end else if (w_mode_chg) begin
            r_acc      <= '0;
            r_psum_vld <= 1'b0;
        end else begin
            r_psum_vld <= r_valid;
            if (r_valid) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    // One guard bit keeps the rounding add exact before the arithmetic shift
    always_comb begin
        w_round = QW'(r_acc) + RND_Q;
        w_shift = w_round >>> FRAC_BITS;
    end

    if (SAT != 0) begin : g_sat
        always_comb begin
            if (w_shift > MAX_Q) begin
                w_result = MAX_Q[DATA_WIDTH-1:0];
            end else if (w_shift < MIN_Q) begin
                w_result = MIN_Q[DATA_WIDTH-1:0];
            end else begin
                w_result = w_shift[DATA_WIDTH-1:0];
            end
        end
    end else begin : g_trunc
        assign w_result = w_shift[DATA_WIDTH-1:0];
    end

    assign bus.valid_o    = r_valid;
    assign bus.clear_o    = r_clear;
    assign bus.wload_o    = r_wload;
    assign bus.srca_o     = r_srca;
    assign bus.srcb_o     = r_srcb;
    assign bus.psum_o     = r_acc;
    assign bus.psum_vld_o = r_psum_vld;
    assign bus.result_o   = w_result;

endmodule

// File: tb/tb_pe_mac_cfg.sv
// Bench for pe_mac_cfg: directed scenarios plus random beats against a
// beat-level arithmetic model, with a saturating and a truncating instance.
module tb_pe_mac_cfg;
    localparam int unsigned DW = 16;
    localparam int unsigned FB = 8;
    localparam int unsigned AW = 40;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    pe_mac_cfg_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus0 ();
    pe_mac_cfg_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus1 ();

    pe_mac_cfg #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW), .SAT(1)) u_dut_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    pe_mac_cfg #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW), .SAT(0)) u_dut_trunc (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    assign bus1.mode_i  = bus0.mode_i;
    assign bus1.valid_i = bus0.valid_i;
    assign bus1.clear_i = bus0.clear_i;
    assign bus1.wload_i = bus0.wload_i;
    assign bus1.srca_i  = bus0.srca_i;
    assign bus1.srcb_i  = bus0.srcb_i;
    assign bus1.psum_i  = bus0.psum_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: accumulator value, stored weight, mode, and the beat in flight
    longint     m_acc;
    longint     m_weight;
    bit         m_mode;
    bit         p_vld;
    bit         p_clr;
    longint     p_prod;
    longint     p_psum;
    bit         e_pvld;
    logic [36:0] e_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint s16(input logic [15:0] v);
        logic signed [15:0] t;
        t = v;
        return longint'(t);
    endfunction

    function automatic longint wrap40(input longint x);
        logic signed [39:0] t;
        t = x[39:0];
        return longint'(t);
    endfunction

    // Round half up at the fraction boundary, then clamp or keep the low bits
    function automatic logic [15:0] quant(input longint acc, input bit sat);
        longint r;
        r = (acc + (longint'(1) << (FB - 1))) >>> FB;
        if (sat) begin
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
        end
        return r[15:0];
    endfunction

    task automatic check_outputs();
        chk("psum",     64'(bus0.psum_o), 64'(m_acc[39:0]));
        chk("psum_vld", 64'(bus0.psum_vld_o), 64'(e_pvld));
        chk("res_sat",  64'(bus0.result_o), 64'(quant(m_acc, 1'b1)));
        chk("res_trunc", 64'(bus1.result_o), 64'(quant(m_acc, 1'b0)));
        chk("passthru", 64'({bus0.valid_o, bus0.clear_o, bus0.wload_o, bus0.srca_o, bus0.srcb_o}),
            64'(e_pass));
    endtask

    task automatic model_reset();
        m_acc = 0; m_weight = 0; m_mode = 1'b0;
        p_vld = 1'b0; p_clr = 1'b0; p_prod = 0; p_psum = 0;
        e_pvld = 1'b0; e_pass = '0;
    endtask

    // Drive one beat at the falling edge, advance the model over the next rising edge, check
    task automatic step(input bit m, input bit v, input bit c, input bit w,
                        input logic [15:0] a, input logic [15:0] b, input logic [39:0] ps);
        longint prod;
        bus0.mode_i  = m;
        bus0.valid_i = v;
        bus0.clear_i = c;
        bus0.wload_i = w;
        bus0.srca_i  = a;
        bus0.srcb_i  = b;
        bus0.psum_i  = ps;
        prod = s16(a) * (m_mode ? m_weight : s16(b));
        if (m_mode != m) begin
            m_acc  = 0;
            e_pvld = 1'b0;
        end else begin
            e_pvld = p_vld;
            if (p_vld) begin
                if (m_mode) m_acc = wrap40(p_psum + p_prod);
                else        m_acc = wrap40((p_clr ? 0 : m_acc) + p_prod);
            end
        end
        p_vld  = v;
        p_clr  = c & v;
        p_prod = prod;
        p_psum = wrap40(longint'(ps));
        if (w) m_weight = s16(b);
        m_mode = m;
        e_pass = {v, c & v, w, a, b};
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit m);
        step(m, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 40'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psum"},  64'(bus0.psum_o), 64'h0);
        chk({tag, "_pvld"},  64'(bus0.psum_vld_o), 64'h0);
        chk({tag, "_res"},   64'({bus0.result_o, bus1.result_o}), 64'h0);
        chk({tag, "_pass"},  64'({bus0.valid_o, bus0.clear_o, bus0.wload_o, bus0.srca_o, bus0.srcb_o}), 64'h0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus0.mode_i = 1'b0; bus0.valid_i = 1'b0; bus0.clear_i = 1'b0; bus0.wload_i = 1'b0;
        bus0.srca_i = '0; bus0.srcb_i = '0; bus0.psum_i = '0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          cur_mode;
        bit          v, c, w;
        logic [15:0] a, b;
        logic [39:0] ps;

        rst_n = 1'b1;
        @(negedge clk);
        apply_reset();

        // OS accumulate 1.5 x 2.0 three times
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0180, 16'h0200, 40'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0180, 16'h0200, 40'h0);
        chk("os_r1", 64'(bus0.result_o), 64'h0300);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0180, 16'h0200, 40'h0);
        chk("os_r2", 64'(bus0.result_o), 64'h0600);
        idle(1'b0);
        chk("os_r3", 64'(bus0.result_o), 64'h0900);
        chk("os_psum", 64'(bus0.psum_o), 64'h90000);
        idle(1'b0);
        chk("os_hold", 64'(bus0.psum_o), 64'h90000);

        // Rounding at the half-LSB point
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0080, 40'h0); idle(1'b0);
        chk("rnd_pos", 64'(bus0.result_o), 64'h0001);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0080, 40'h0); idle(1'b0);
        chk("rnd_half_neg", 64'(bus0.result_o), 64'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0081, 40'h0); idle(1'b0);
        chk("rnd_neg", 64'(bus0.result_o), 64'hFFFF);

        // Saturation versus truncation
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h7F00, 16'h7F00, 40'h0); idle(1'b0);
        chk("sat_hi", 64'(bus0.result_o), 64'h7FFF);
        chk("trunc_hi", 64'(bus1.result_o), 64'h0100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h7F00, 40'h0); idle(1'b0);
        chk("sat_lo", 64'(bus0.result_o), 64'h8000);
        chk("trunc_lo", 64'(bus1.result_o), 64'h8000);

        // Gaps and clear without valid
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 40'h0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100, 40'h0);
        chk("clr_novld", 64'(bus0.clear_o), 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 40'h0);
        idle(1'b0);
        chk("gap_acc", 64'(bus0.psum_o), 64'h20000);

        // Weight-stationary, including a weight load alongside a beat
        idle(1'b0); idle(1'b0);
        idle(1'b1);
        chk("mode_flush", 64'(bus0.psum_o), 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 40'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 40'h10000); idle(1'b1);
        chk("ws_psum", 64'(bus0.psum_o), 64'h30000);
        chk("ws_res", 64'(bus0.result_o), 64'h0300);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0400, 40'h10000); idle(1'b1);
        chk("ws_oldw", 64'(bus0.psum_o), 64'h30000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 40'h10000); idle(1'b1);
        chk("ws_neww", 64'(bus0.psum_o), 64'h50000);

        // Reset mid-accumulation, then a beat without clear starts from zero
        idle(1'b1); idle(1'b1); idle(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0300, 40'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0300, 40'h0);
        apply_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 40'h0); idle(1'b0);
        chk("post_rst", 64'(bus0.result_o), 64'h0100);

        // Random traffic with occasional idle-bracketed mode switches
        cur_mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                idle(cur_mode); idle(cur_mode);
                cur_mode = ~cur_mode;
                idle(cur_mode);
            end
            v  = ($urandom_range(0, 9) < 6);
            c  = ($urandom_range(0, 4) == 0);
            w  = ($urandom_range(0, 6) == 0);
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a = 16'(int'($urandom_range(0, 1023)) - 512);
                b = 16'(int'($urandom_range(0, 1023)) - 512);
            end
            ps = 40'({$urandom, $urandom});
            step(cur_mode, v, c, w, a, b, ps);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
